// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit.
//   OP_*    : 2-bit opcode encodings presented on the op port
//   state_t : controller state encoding
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/addsub_n.sv
// N-bit ripple-carry adder/subtractor.
//   x, y  : operands
//   mode  : 0 -> s = x + y + cin, 1 -> s = x - y - cin
//   cin   : carry-in (add) or borrow-in (sub)
//   s     : N-bit sum/difference
//   cout  : carry-out (add) or borrow-out (sub)
module addsub_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         mode,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N-1:0] y_eff;
    logic [N:0]   c;

    // Subtraction is x + ~y + 1; borrow is the inverted carry.
    always_comb begin
        y_eff = y ^ {N{mode}};
        c     = '0;
        c[0]  = cin ^ mode;
        s     = '0;
        for (int i = 0; i < N; i++) begin
            s[i]   = x[i] ^ y_eff[i] ^ c[i];
            c[i+1] = (x[i] & y_eff[i]) | (c[i] & (x[i] ^ y_eff[i]));
        end
        cout = c[N] ^ mode;
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle add/sub/mul/div unit sharing one N-bit adder/subtractor.
//   clk, rst      : clock, synchronous active-high reset
//   start, op     : request and operation select (sampled in IDLE only)
//   a, b          : N-bit operands
//   busy          : high while not IDLE
//   done          : one-cycle completion pulse
//   result        : 2N-bit result (div: {remainder, quotient})
//   flag          : carry (add) / borrow (sub), 0 otherwise
//   err           : divide-by-zero
//
// state | meaning
// IDLE  | waiting for start; add/sub evaluated on the accept edge
// CALC  | one multiply/divide bit per cycle, down-counter terminates at 1
// DONE  | done pulse, outputs freshly valid
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [2*N-1:0] result,
    output logic         flag,
    output logic         err
);

    localparam int CW = $clog2(N) + 1;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [N-1:0]   opnd_q, opnd_d;   // multiplicand (mul) or divisor (div)
    logic [N-1:0]   hi_q, hi_d;       // partial product high / remainder
    logic [N-1:0]   lo_q, lo_d;       // multiplier / quotient, shifted in place
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] result_q, result_d;
    logic           flag_q, flag_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [N-1:0]   as_x, as_y, as_s;
    logic           as_mode, as_co;
    logic [N-1:0]   trial_x;
    logic           fits;

    addsub_n #(.N(N)) u_addsub (
        .x    (as_x),
        .y    (as_y),
        .mode (as_mode),
        .cin  (1'b0),
        .s    (as_s),
        .cout (as_co)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flag_d   = flag_q;
        err_d    = err_q;
        as_x     = a;
        as_y     = b;
        as_mode  = (op == OP_SUB);
        // Divide step: shift remainder left, bring in next dividend bit.
        trial_x  = {hi_q[N-2:0], lo_q[N-1]};
        fits     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op;
                    case (op)
                        OP_ADD: begin
                            result_d = {{(N-1){1'b0}}, as_co, as_s};
                            flag_d   = as_co;
                            err_d    = 1'b0;
                            state_d  = DONE;
                        end
                        OP_SUB: begin
                            result_d = {{N{1'b0}}, as_s};
                            flag_d   = as_co;
                            err_d    = 1'b0;
                            state_d  = DONE;
                        end
                        OP_MUL: begin
                            opnd_d  = a;
                            hi_d    = '0;
                            lo_d    = b;
                            cnt_d   = CW'(N);
                            state_d = CALC;
                        end
                        default: begin
                            if (b == '0) begin
                                result_d = {a, {N{1'b1}}};
                                flag_d   = 1'b0;
                                err_d    = 1'b1;
                                state_d  = DONE;
                            end else begin
                                opnd_d  = b;
                                hi_d    = '0;
                                lo_d    = a;
                                cnt_d   = CW'(N);
                                state_d = CALC;
                            end
                        end
                    endcase
                end
            end
            CALC: begin
                if (op_q == OP_MUL) begin
                    as_x    = hi_q;
                    as_y    = lo_q[0] ? opnd_q : '0;
                    as_mode = 1'b0;
                    hi_d    = {as_co, as_s[N-1:1]};
                    lo_d    = {as_s[0], lo_q[N-1:1]};
                end else begin
                    as_x    = trial_x;
                    as_y    = opnd_q;
                    as_mode = 1'b1;
                    // A set remainder MSB means the shifted value is >= 2^N,
                    // which always exceeds the divisor.
                    fits    = hi_q[N-1] | ~as_co;
                    hi_d    = fits ? as_s : trial_x;
                    lo_d    = {lo_q[N-2:0], fits};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = {hi_d, lo_d};
                    flag_d   = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flag   = flag_q;
    assign err    = err_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
module tb_seq_arith_unit;

    localparam int N = 4;

    typedef struct {
        logic [2*N-1:0] res;
        logic           flag;
        logic           err;
    } exp_t;

    typedef struct {
        logic [1:0]     op;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] res;
        logic           flag;
        logic           err;
        int             lat;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     op;
    logic [N-1:0]   a, b;
    logic           busy, done, flag, err;
    logic [2*N-1:0] result;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    vec_t tbl[14];

    seq_arith_unit #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag   (flag),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain arithmetic reference, independent of the iterative datapath.
    function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        int   xi, yi;
        xi     = int'(x);
        yi     = int'(y);
        e.flag = 1'b0;
        e.err  = 1'b0;
        case (o)
            2'b00: begin
                e.res  = (2*N)'(xi + yi);
                e.flag = (xi + yi) >= (1 << N);
            end
            2'b01: begin
                e.res  = (2*N)'((xi - yi) & ((1 << N) - 1));
                e.flag = xi < yi;
            end
            2'b10: e.res = (2*N)'(xi * yi);
            default: begin
                if (yi == 0) begin
                    e.res = {x, {N{1'b1}}};
                    e.err = 1'b1;
                end else begin
                    e.res = (2*N)'(((xi % yi) << N) | (xi / yi));
                end
            end
        endcase
        return e;
    endfunction

    // Scoreboard: every done pops one expected record.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("stray_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("flag", 32'(flag), 32'(e.flag));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                         input exp_t e, input int exp_lat);
        int  lat;
        int  wait_cyc;
        bit  busy_ok;
        wait_cyc = 0;
        @(negedge clk);
        while (busy && wait_cyc < 40) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("idle_before_issue", 32'(busy), 32'd0);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb_q.push_back(e);
        @(posedge clk);
        lat     = 0;
        busy_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            a     = ~x;
            b     = ~y;
            lat++;
            if (!busy) busy_ok = 1'b0;
            if (done) break;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_while_active", 32'(busy_ok), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("result_hold", 32'(result), 32'(e.res));
    endtask

    initial begin
        int   first_done, second_done, n_done;
        exp_t e;

        tbl[0]  = '{2'b00, 4'd9,  4'd8,  8'h11, 1'b1, 1'b0, 1};
        tbl[1]  = '{2'b00, 4'd15, 4'd15, 8'h1E, 1'b1, 1'b0, 1};
        tbl[2]  = '{2'b00, 4'd3,  4'd4,  8'h07, 1'b0, 1'b0, 1};
        tbl[3]  = '{2'b01, 4'd3,  4'd5,  8'h0E, 1'b1, 1'b0, 1};
        tbl[4]  = '{2'b01, 4'd5,  4'd3,  8'h02, 1'b0, 1'b0, 1};
        tbl[5]  = '{2'b01, 4'd7,  4'd7,  8'h00, 1'b0, 1'b0, 1};
        tbl[6]  = '{2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, 5};
        tbl[7]  = '{2'b10, 4'd0,  4'd7,  8'h00, 1'b0, 1'b0, 5};
        tbl[8]  = '{2'b10, 4'd13, 4'd11, 8'h8F, 1'b0, 1'b0, 5};
        tbl[9]  = '{2'b11, 4'd13, 4'd4,  8'h13, 1'b0, 1'b0, 5};
        tbl[10] = '{2'b11, 4'd7,  4'd0,  8'h7F, 1'b0, 1'b1, 1};
        tbl[11] = '{2'b11, 4'd15, 4'd1,  8'h0F, 1'b0, 1'b0, 5};
        tbl[12] = '{2'b11, 4'd2,  4'd7,  8'h20, 1'b0, 1'b0, 5};
        tbl[13] = '{2'b11, 4'd15, 4'd15, 8'h01, 1'b0, 1'b0, 5};

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flag_err", 32'({flag, err}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            e.res  = tbl[i].res;
            e.flag = tbl[i].flag;
            e.err  = tbl[i].err;
            issue(tbl[i].op, tbl[i].a, tbl[i].b, e, tbl[i].lat);
        end

        for (int i = 0; i < 24; i++) begin
            logic [1:0]   ro;
            logic [N-1:0] ra, rb;
            int           rl;
            ro = 2'($urandom_range(0, 3));
            ra = N'($urandom_range(0, 15));
            rb = N'($urandom_range(0, 15));
            rl = (ro[1] && !(ro == 2'b11 && rb == '0)) ? N + 1 : 1;
            issue(ro, ra, rb, model(ro, ra, rb), rl);
        end

        // start held high through a multiply; operands change mid-CALC.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 4'd15;
        b     = 4'd15;
        e.res = 8'hE1; e.flag = 1'b0; e.err = 1'b0;
        sb_q.push_back(e);
        e.res = 8'h06;
        sb_q.push_back(e);
        @(posedge clk);
        first_done  = -1;
        second_done = -1;
        n_done      = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a = 4'd2;
                b = 4'd3;
            end
            if (c == 6) check("hs_idle_gap", 32'(busy), 32'd0);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (c == 11) start = 1'b0;
        end
        check("hs_first_done", 32'(first_done), 32'd5);
        check("hs_second_done", 32'(second_done), 32'd11);
        check("hs_done_count", 32'(n_done), 32'd2);

        // Reset during CALC.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 4'd15;
        b     = 4'd15;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_flag_err", 32'({flag, err}), 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        e.res = 8'h02; e.flag = 1'b0; e.err = 1'b0;
        issue(2'b00, 4'd1, 4'd1, e, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
